// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and frame constants
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int DATA_BITS = 8;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for an asynchronous single-bit input
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver with mid-bit sampling, glitch reject and framing check
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 65_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int BIT_CYC  = CLK_HZ / BAUD;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CW       = $clog2(BIT_CYC);
  localparam int IDX_W    = $clog2(DATA_BITS);

  localparam logic [CW-1:0]    CNT_HALF = CW'(HALF_CYC - 1);
  localparam logic [CW-1:0]    CNT_BIT  = CW'(BIT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  if (BIT_CYC < 4) begin : g_bit_cyc_check
    $error("uart_rx_byte: CLK_HZ/BAUD must be at least 4");
  end

  uart_state_t          state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] sr, sr_nxt;
  logic [7:0]           rx_data_nxt;
  logic                 rx_valid_nxt, frame_err_nxt;
  logic                 rxs;

  // Idle-high preset keeps a reset release from looking like a start edge.
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxs)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      sr        <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      sr        <= sr_nxt;
      rx_data   <= rx_data_nxt;
      rx_valid  <= rx_valid_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt + 1'b1;
    bit_idx_nxt   = bit_idx;
    sr_nxt        = sr;
    rx_data_nxt   = rx_data;
    rx_valid_nxt  = 1'b0;
    frame_err_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rxs) begin
          state_nxt = START;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_BIT) begin
          cnt_nxt = '0;
          sr_nxt  = {rxs, sr[DATA_BITS-1:1]};
          if (bit_idx == IDX_LAST) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (cnt == CNT_BIT) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          if (rxs) begin
            rx_data_nxt  = sr;
            rx_valid_nxt = 1'b1;
          end else begin
            frame_err_nxt = 1'b1;
          end
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - randomized scoreboard bench for uart_rx_byte
module tb_uart_rx_byte;

  localparam int CLK_HZ  = 1_000_000;
  localparam int BAUD    = 100_000;
  localparam int BITC    = CLK_HZ / BAUD;
  localparam int LAT     = 2 + BITC / 2 + 9 * BITC;
  localparam int RETRIG  = BITC / 2 + 9 * BITC + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, busy;

  uart_rx_byte #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         lo;
    int         hi;
    bit         err;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] exp_data = 8'h00;
  int cyc = 0, checks = 0, failures = 0;
  int n_valid = 0, n_ferr = 0, last_pulse_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, req, cyc);
    end
  endfunction

  // Scoreboard: each frame sent predicts one pulse inside a latency window.
  always @(negedge clk) begin : cmp
    ev_t e;
    if (!rst) begin
      chk("reset_rx_data", rx_data, 0);
      chk("reset_rx_valid", rx_valid, 0);
      chk("reset_frame_err", frame_err, 0);
      chk("reset_busy", busy, 0);
    end else begin
      if (rx_valid || frame_err) begin
        chk("pulse_exclusive", int'(rx_valid && frame_err), 0);
        if (rx_valid) n_valid++;
        if (frame_err) n_ferr++;
        last_pulse_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", int'({rx_valid, frame_err}), 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_window", int'(cyc >= e.lo && cyc <= e.hi), 1);
          chk("pulse_kind_ferr", int'(frame_err), int'(e.err));
          if (!e.err) exp_data = e.data;
        end
      end else begin
        chk("pulse_deadline", int'(exp_q.size() == 0 || cyc <= exp_q[0].hi), 1);
        if (exp_q.size() != 0 && cyc > exp_q[0].hi) void'(exp_q.pop_front());
      end
      chk("rx_data", rx_data, exp_data);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      rxd = 1'b1;
      @(negedge clk);
    end
  endtask

  // jit: 0 exact cells, 1 random +/-1 cycle, 2/3 alternating 9/11-cycle cells.
  task automatic send_frame(input logic [7:0] b, input bit stop_hi, input int jit);
    int   w[10];
    logic lvl[10];
    int   dev, d, t, n0;
    ev_t  e;
    dev = 0;
    lvl[0] = 1'b0;
    lvl[9] = stop_hi;
    for (int k = 1; k < 9; k++) lvl[k] = b[k-1];
    for (int k = 0; k < 10; k++) begin
      case (jit)
        1:       d = int'($urandom_range(0, 2)) - 1;
        2:       d = (k % 2 == 0) ? -1 : 1;
        3:       d = (k % 2 == 0) ? 1 : -1;
        default: d = 0;
      endcase
      if (dev + d > 1 || dev + d < -1) d = 0;
      dev += d;
      w[k] = BITC + d;
    end
    n0 = cyc;
    e.lo = n0 + LAT;
    e.hi = n0 + LAT + 1;
    e.err = !stop_hi;
    e.data = b;
    exp_q.push_back(e);
    t = 0;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < w[k]; j++) begin
        rxd = lvl[k];
        if (t % BITC == 5 && t <= 9 * BITC + 5) chk("busy_in_frame", busy, 1);
        @(negedge clk);
        t++;
      end
    end
  endtask

  task automatic glitch(input int len);
    for (int t = 0; t < 12; t++) begin
      rxd = (t < len) ? 1'b0 : 1'b1;
      if (t == 4) chk("busy_glitch_start", busy, 1);
      if (t == 10) chk("busy_glitch_idle", busy, 0);
      @(negedge clk);
    end
  endtask

  // A held-low line retriggers a new frame at each stop-bit sample point.
  task automatic send_break();
    ev_t e;
    int  n0;
    n0 = cyc;
    e.err = 1'b1;
    e.data = 8'h00;
    e.lo = n0 + LAT;
    e.hi = n0 + LAT + 1;
    exp_q.push_back(e);
    e.lo = n0 + LAT + RETRIG;
    e.hi = n0 + LAT + RETRIG + 1;
    exp_q.push_back(e);
    repeat (2 * RETRIG + 2) begin
      rxd = 1'b0;
      @(negedge clk);
    end
    idle(30);
  endtask

  task automatic reset_mid_frame(input logic [7:0] b);
    rxd = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      rxd = b[k];
      repeat (BITC) @(negedge clk);
    end
    #2;
    rst = 1'b0;
    rxd = 1'b1;
    #1;
    chk("async_reset_busy", busy, 0);
    chk("async_reset_rx_data", rx_data, 0);
    exp_q.delete();
    exp_data = 8'h00;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int  nv, nf, t1, kind;
    bit  prev_bad;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    idle(5);

    nv = n_valid; nf = n_ferr; t1 = cyc;
    send_frame(8'hA5, 1'b1, 0);
    idle(20);
    chk("t1_valid_count", n_valid - nv, 1);
    chk("t1_rx_data", rx_data, 8'hA5);
    chk("t1_latency", int'(last_pulse_cyc - t1 >= LAT && last_pulse_cyc - t1 <= LAT + 1), 1);

    nv = n_valid; nf = n_ferr;
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    idle(20);
    chk("t2_valid_count", n_valid - nv, 2);
    chk("t2_ferr_count", n_ferr - nf, 0);
    chk("t2_rx_data", rx_data, 8'hFF);

    nv = n_valid; nf = n_ferr;
    glitch(3);
    idle(10);
    chk("t3_valid_count", n_valid - nv, 0);
    chk("t3_ferr_count", n_ferr - nf, 0);
    chk("t3_rx_data", rx_data, 8'hFF);

    nv = n_valid; nf = n_ferr;
    send_frame(8'h3C, 1'b0, 0);
    idle(15);
    chk("t4_ferr_count", n_ferr - nf, 1);
    chk("t4_rx_data_kept", rx_data, 8'hFF);
    send_frame(8'h55, 1'b1, 0);
    idle(20);
    chk("t4_valid_count", n_valid - nv, 1);
    chk("t4_rx_data", rx_data, 8'h55);

    reset_mid_frame(8'h96);
    nv = n_valid; nf = n_ferr;
    idle(10);
    chk("t5_rx_data_reset", rx_data, 8'h00);
    send_frame(8'h81, 1'b1, 0);
    idle(20);
    chk("t5_valid_count", n_valid - nv, 1);
    chk("t5_ferr_count", n_ferr - nf, 0);
    chk("t5_rx_data", rx_data, 8'h81);

    nv = n_valid;
    send_frame(8'hC3, 1'b1, 2);
    idle(5);
    send_frame(8'hC3, 1'b1, 3);
    idle(20);
    chk("t6_valid_count", n_valid - nv, 2);
    chk("t6_rx_data", rx_data, 8'hC3);

    nv = n_valid; nf = n_ferr;
    send_break();
    chk("break_ferr_count", n_ferr - nf, 2);
    chk("break_valid_count", n_valid - nv, 0);

    prev_bad = 1'b1;
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 9));
      if (prev_bad || $urandom_range(0, 1) == 1) idle(12 + int'($urandom_range(0, 20)));
      if (kind == 9) begin
        glitch(int'($urandom_range(1, 4)));
        prev_bad = 1'b1;
      end else begin
        send_frame(8'($urandom), kind <= 6, int'($urandom_range(0, 1)));
        prev_bad = (kind > 6);
      end
    end
    idle(150);
    chk("pending_events", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
